// File: rtl/ram_port_arbiter_pkg.sv
// ram_arb_pkg: shared types and default constants for the RAM port arbiter.
// Contents:
//   arbState_t   - arbitration FSM state (IDLE: no owner, LOCKED: owner held)
//   master_id_t  - one-bit requester index (0 = load/store unit, 1 = host loader)
//   rdEntry_t    - read-return tag carried alongside the RAM read latency
//   DEF_*        - default parameter values for the arbiter
package ram_arb_pkg;

  localparam int DEF_ADDR_W    = 14;
  localparam int DEF_DATA_W    = 256;
  localparam int DEF_BE_W      = DEF_DATA_W / 8;
  localparam int DEF_RD_LAT    = 2;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arbState_t;

  typedef logic master_id_t;

  typedef struct packed {
    logic       valid;
    master_id_t id;
  } rdEntry_t;

endpackage

// File: rtl/ram_port_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: fixed-depth shift register of read-return tags.
// Each accepted read enters at the head; the entry leaving the tail lines up
// with the cycle the RAM presents the data for that read.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset (clears every stage)
//   inEntry     - tag for the beat granted this cycle
//   outEntry    - tag whose read data is on the RAM read bus this cycle
module rd_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int DEPTH = DEF_RD_LAT + 1
) (
  input  logic     clk,
  input  logic     reset,
  input  rdEntry_t inEntry,
  output rdEntry_t outEntry
);

  rdEntry_t stages [DEPTH];

  // Clearing every stage on reset drops in-flight reads so no stale rvalid
  // can surface once reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= inEntry;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign outEntry = stages[DEPTH-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single data RAM port between master 0 (vector
// load/store unit) and master 1 (host/debug loader). Round-robin arbitration
// with an optional short lock for bursts, a registered RAM-port stage, and
// routing of read data back to the issuing master after the RAM latency.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   mN_req/wr/lock/addr/be/wdata - master N request beat
//   mN_gnt                     - beat accepted this cycle (combinational)
//   mN_rvalid, mN_rdata        - read return for master N
//   readData_RAM               - RAM read data
//   address_RAM, byteena_RAM, writeData_RAM, rden_RAM, wren_RAM - RAM port
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BE_W      = DEF_BE_W,
  parameter int RD_LAT    = DEF_RD_LAT,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [BE_W-1:0]   m0_be,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [BE_W-1:0]   m1_be,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic [DATA_W-1:0] readData_RAM,
  output logic [ADDR_W-1:0] address_RAM,
  output logic [BE_W-1:0]   byteena_RAM,
  output logic [DATA_W-1:0] writeData_RAM,
  output logic              rden_RAM,
  output logic              wren_RAM
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arbState_t        state, stateNext;
  master_id_t       owner, ownerNext;
  master_id_t       lastWinner, lastWinnerNext;
  logic [CNT_W-1:0] burstCnt, burstCntNext;
  logic             grantValid;
  master_id_t       grantId;
  logic [1:0]       reqVec, lockVec;

  logic              selWr;
  logic [ADDR_W-1:0] selAddr;
  logic [BE_W-1:0]   selBe;
  logic [DATA_W-1:0] selWdata;

  rdEntry_t          pipeIn, pipeOut;
  logic [DATA_W-1:0] heldRdata0, heldRdata1;

  assign reqVec  = {m1_req, m0_req};
  assign lockVec = {m1_lock, m0_lock};

  // Arbitration state register; lastWinner starts at 1 so master 0 wins the
  // first tie after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      lastWinner <= 1'b1;
      burstCnt   <= '0;
    end else begin
      state      <= stateNext;
      owner      <= ownerNext;
      lastWinner <= lastWinnerNext;
      burstCnt   <= burstCntNext;
    end
  end

  // Grant selection and next state. In LOCKED, the waiting master steals the
  // port once the owner has used MAX_BURST beats; that grant also ends the
  // lock unless the stealing beat itself asks for one.
  always_comb begin
    grantValid     = 1'b0;
    grantId        = owner;
    stateNext      = state;
    ownerNext      = owner;
    lastWinnerNext = lastWinner;
    burstCntNext   = burstCnt;

    if (state == IDLE) begin
      if (m0_req && m1_req) begin
        grantValid = 1'b1;
        grantId    = ~lastWinner;
      end else if (m0_req) begin
        grantValid = 1'b1;
        grantId    = 1'b0;
      end else if (m1_req) begin
        grantValid = 1'b1;
        grantId    = 1'b1;
      end
    end else begin
      if ((burstCnt == CNT_MAX) && reqVec[~owner]) begin
        grantValid = 1'b1;
        grantId    = ~owner;
      end else if (reqVec[owner]) begin
        grantValid = 1'b1;
        grantId    = owner;
      end
    end

    if (grantValid) begin
      lastWinnerNext = grantId;
      if (lockVec[grantId]) begin
        stateNext = LOCKED;
        if ((state == LOCKED) && (grantId == owner)) begin
          // Saturate so a lone locked owner keeps the port until challenged.
          if (burstCnt < CNT_MAX) begin
            burstCntNext = burstCnt + CNT_ONE;
          end
        end else begin
          ownerNext    = grantId;
          burstCntNext = CNT_ONE;
        end
      end else begin
        stateNext    = IDLE;
        burstCntNext = '0;
      end
    end else if (state == LOCKED) begin
      stateNext    = IDLE;
      burstCntNext = '0;
    end
  end

  // Grants are forced low during reset so every output reads 0 immediately.
  assign m0_gnt = !reset && grantValid && (grantId == 1'b0);
  assign m1_gnt = !reset && grantValid && (grantId == 1'b1);

  assign selWr    = grantId ? m1_wr    : m0_wr;
  assign selAddr  = grantId ? m1_addr  : m0_addr;
  assign selBe    = grantId ? m1_be    : m0_be;
  assign selWdata = grantId ? m1_wdata : m0_wdata;

  // Registered RAM-port stage. Address and write data hold between beats;
  // byte enables are only non-zero on a write beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_RAM   <= '0;
      byteena_RAM   <= '0;
      writeData_RAM <= '0;
      rden_RAM      <= 1'b0;
      wren_RAM      <= 1'b0;
    end else begin
      rden_RAM    <= grantValid && !selWr;
      wren_RAM    <= grantValid && selWr;
      byteena_RAM <= (grantValid && selWr) ? selBe : '0;
      if (grantValid) begin
        address_RAM <= selAddr;
      end
      if (grantValid && selWr) begin
        writeData_RAM <= selWdata;
      end
    end
  end

  assign pipeIn = '{valid: (grantValid && !selWr), id: grantId};

  rd_tag_pipe #(
    .DEPTH(RD_LAT + 1)
  ) uRdTagPipe (
    .clk     (clk),
    .reset   (reset),
    .inEntry (pipeIn),
    .outEntry(pipeOut)
  );

  assign m0_rvalid = pipeOut.valid && (pipeOut.id == 1'b0);
  assign m1_rvalid = pipeOut.valid && (pipeOut.id == 1'b1);

  // Remember each master's last returned word so its rdata holds while the
  // RAM bus carries the other master's data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      heldRdata0 <= '0;
      heldRdata1 <= '0;
    end else begin
      if (m0_rvalid) begin
        heldRdata0 <= readData_RAM;
      end
      if (m1_rvalid) begin
        heldRdata1 <= readData_RAM;
      end
    end
  end

  assign m0_rdata = m0_rvalid ? readData_RAM : heldRdata0;
  assign m1_rdata = m1_rvalid ? readData_RAM : heldRdata1;

endmodule
